alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the MIPS datapath, the successor to the combinational single-cycle ALU. It keeps the ADD/SUB/AND/OR/XOR encodings and adds SLT, shifts, and iterative unsigned multiply and divide. Every operation uses a start/done handshake. Compare flags are registered with the result and are defined on every operation. It sits in the execute stage; the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 4 and a power of 2.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `start`  in  1: request; accepted only when `busy`=0.
- `aluoperation`  in  4: opcode, sampled at accept.
- `data1`, `data2`  in  WIDTH: operands, sampled at accept.
- `result`  out  WIDTH: registered result; holds until the next completion.
- `hi`  out  WIDTH: MULU upper product or DIVU remainder; otherwise 0.
- `zero`  out  1: `result`==0, registered with `result`.
- `lt`, `gt`  out  1: unsigned `data1`<`data2` / `data1`>`data2` of accepted operands; both 0 when equal.
- `busy`  out  1: high in ITER.
- `done`  out  1: one-cycle pulse, high in the cycle after the result/flags register update.

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR: all wrap modulo 2^WIDTH.
  - 0101 SLT: signed compare, result 1 or 0.
  - 0110 SLL, 0111 SRL: logical shifts by `data2[SHW-1:0]`.
  - 1000 MULU, 1001 DIVU: iterative.
  - Any other opcode executes as ADD.
- States: IDLE, ITER, DONE. Reset state is IDLE.
- IDLE or DONE with `start`=1:
  - Single-cycle op: compute result, flags and `hi`=0; go to DONE.
  - MULU/DIVU: latch operands, clear the accumulator, set cnt=0; go to ITER.
- IDLE or DONE with `start`=0: go to (or stay in) IDLE.
- ITER:
  - Each cycle performs one shift-add step (MULU) or one restoring-subtract step (DIVU), then cnt++.
  - On the step where cnt==WIDTH-1: load `result`/`hi`/flags and go to DONE.
- `start` is ignored while in ITER. There is no queueing; the requester must hold or re-issue.
- MULU: `{hi,result}` = full 2·WIDTH-bit unsigned product.
- DIVU: `result` = quotient, `hi` = remainder.
- DIVU by 0: `result` = all ones, `hi` = `data1`. This falls out of restoring division; no special case is needed.
- `zero` always reflects the final `result` (not `hi`).
- `lt`/`gt` come from the operands captured at accept, for every opcode.
- Operands may change freely after the accept edge.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `result`=0, `hi`=0, `zero`=0, `lt`=0, `gt`=0, `busy`=0, `done`=0, cnt=0.
- Reset mid-ITER aborts the operation. No `done` is produced and the partial result is discarded.
- Single-cycle op accepted at edge k: `result`/flags valid and `done`=1 after edge k.
- MULU/DIVU accepted at edge k:
  - `busy`=1 after edges k .. k+WIDTH-1.
  - `result`/`hi`/flags valid and `done`=1 after edge k+WIDTH.
  - Latency is WIDTH+1 cycles; 33 for WIDTH=32.
- Back-to-back: `start` in the DONE cycle is accepted. This gives a throughput of 1 op/cycle for single-cycle ops.
- `done` is never high for two consecutive cycles unless a new op was accepted in the DONE cycle.

## Test plan
- Reset, then ADD `data1`=1, `data2`=2 at edge k:
  - `result`=3, `zero`=0, `lt`=1, `gt`=0 and `done`=1 after edge k; `done`=0 the next cycle.
- SUB 5−5: `result`=0, `zero`=1, `lt`=`gt`=0.
- Back-to-back: OR 0xF0|0x0F, then SRL 0x8000_0000 by 31 in the DONE cycle:
  - `result`=0xFF, then 1, on consecutive cycles.
  - SLT 0xFFFF_FFFF vs 1 → 1.
- MULU 0xFFFF_FFFF × 2:
  - `busy` high for exactly 32 cycles; `done` after edge k+32.
  - `result`=0xFFFF_FFFE, `hi`=1.
  - A `start` pulse with ADD mid-ITER is ignored: `result` is unchanged and there is no extra `done`.
- DIVU 100/7 → `result`=14, `hi`=2. DIVU 9/0 → `result`=0xFFFF_FFFF, `hi`=9, `zero`=0.
- Reset mid-operation: assert `rst_n`=0 for one edge during DIVU ITER.
  - All outputs return to reset values and `done` never pulses.
  - A following ADD 4+4 completes with 8.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic/SLT/shifts plus iterative unsigned MULU/DIVU.
// A start/done handshake is used for every operation; busy is high while iterating.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluoperation,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             lt,
  output logic             gt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  localparam logic [3:0] OpMulu = 4'b1000;
  localparam logic [3:0] OpDivu = 4'b1001;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             zero_q, zero_d, lt_q, lt_d, gt_q, gt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic             is_div_q, is_div_d, cmp_lt_q, cmp_lt_d, cmp_gt_q, cmp_gt_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    case (aluoperation)
      4'b0001: alu_res = data1 - data2;
      4'b0010: alu_res = data1 & data2;
      4'b0011: alu_res = data1 | data2;
      4'b0100: alu_res = data1 ^ data2;
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
      4'b0110: alu_res = data1 << data2[SHW-1:0];
      4'b0111: alu_res = data1 >> data2[SHW-1:0];
      default: alu_res = data1 + data2;
    endcase
  end

  // One iteration step. For both ops {acc_hi, acc_lo} ends as {hi, result}.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      {step_hi, step_lo} = {mul_sum, acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    cmp_lt_d = cmp_lt_q;
    cmp_gt_d = cmp_gt_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIter: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          result_d = step_lo;
          hi_d     = step_hi;
          zero_d   = (step_lo == '0);
          lt_d     = cmp_lt_q;
          gt_d     = cmp_gt_q;
          state_d  = StDone;
        end
      end
      default: begin
        if (start) begin
          if (aluoperation == OpMulu || aluoperation == OpDivu) begin
            is_div_d = (aluoperation == OpDivu);
            acc_hi_d = '0;
            acc_lo_d = (aluoperation == OpDivu) ? data1 : data2;
            opnd_d   = (aluoperation == OpDivu) ? data2 : data1;
            cmp_lt_d = data1 < data2;
            cmp_gt_d = data1 > data2;
            cnt_d    = '0;
            state_d  = StIter;
          end else begin
            result_d = alu_res;
            hi_d     = '0;
            zero_d   = (alu_res == '0);
            lt_d     = data1 < data2;
            gt_d     = data1 > data2;
            state_d  = StDone;
          end
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cmp_lt_q <= 1'b0;
      cmp_gt_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      cmp_lt_q <= cmp_lt_d;
      cmp_gt_q <= cmp_gt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = result_q;
  assign hi     = hi_q;
  assign zero   = zero_q;
  assign lt     = lt_q;
  assign gt     = gt_q;
  assign busy   = (state_q == StIter);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32) with hand-computed expected values.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  aluoperation;
  logic [31:0] data1, data2;
  logic [31:0] result, hi;
  logic        zero, lt, gt, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .aluoperation (aluoperation),
    .data1        (data1),
    .data2        (data2),
    .result       (result),
    .hi           (hi),
    .zero         (zero),
    .lt           (lt),
    .gt           (gt),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next edge, then wait (bounded) for done.
  task automatic go(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                    output int cyc);
    start = 1'b1; aluoperation = op; data1 = a; data2 = b;
    @(posedge clk); #1;
    start = 1'b0; data1 = '0; data2 = '0;
    cyc = 0;
    while (!done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int n;
    logic seen_done;

    rst_n = 1'b0; start = 1'b0; aluoperation = '0; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h0);
    chk("rst_ltgt", {30'b0, lt, gt}, 32'h0);
    chk("rst_busy_done", {30'b0, busy, done}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    go(4'b0000, 32'd1, 32'd2, cyc);
    chk("add_lat", cyc, 32'd0);
    chk("add_result", result, 32'd3);
    chk("add_flags", {29'b0, zero, lt, gt}, 32'b010);
    chk("add_done", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    chk("add_done_drop", {31'b0, done}, 32'd0);
    chk("add_hold", result, 32'd3);

    go(4'b0001, 32'd5, 32'd5, cyc);
    chk("sub_result", result, 32'd0);
    chk("sub_flags", {29'b0, zero, lt, gt}, 32'b100);
    @(posedge clk); #1;

    // Back-to-back single-cycle ops, start held through DONE cycles.
    start = 1'b1; aluoperation = 4'b0011; data1 = 32'hF0; data2 = 32'h0F;
    @(posedge clk); #1;
    chk("or_result", result, 32'hFF);
    chk("or_done", {31'b0, done}, 32'd1);
    aluoperation = 4'b0111; data1 = 32'h8000_0000; data2 = 32'd31;
    @(posedge clk); #1;
    chk("srl_result", result, 32'd1);
    chk("srl_done", {31'b0, done}, 32'd1);
    aluoperation = 4'b0101; data1 = 32'hFFFF_FFFF; data2 = 32'd1;
    @(posedge clk); #1;
    chk("slt_result", result, 32'd1);
    chk("slt_ltgt", {30'b0, lt, gt}, 32'b01);
    aluoperation = 4'b0110; data1 = 32'd3; data2 = 32'h0000_0124;  // shift uses low 5 bits = 4
    @(posedge clk); #1;
    chk("sll_result", result, 32'h30);
    aluoperation = 4'b0100; data1 = 32'hFF; data2 = 32'h0F;
    @(posedge clk); #1;
    chk("xor_result", result, 32'hF0);
    aluoperation = 4'b0010; data1 = 32'hF0F0; data2 = 32'h0FF0;
    @(posedge clk); #1;
    chk("and_result", result, 32'h00F0);
    aluoperation = 4'b1111; data1 = 32'hFFFF_FFFF; data2 = 32'd1;
    @(posedge clk); #1;
    chk("dflt_add_wrap", result, 32'h0);
    chk("dflt_zero", {31'b0, zero}, 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done_drop", {31'b0, done}, 32'd0);

    // MULU with an ignored start pulse mid-iteration.
    start = 1'b1; aluoperation = 4'b1000; data1 = 32'hFFFF_FFFF; data2 = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; data1 = 32'h1234; data2 = 32'h5678;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 10) begin
        start = 1'b1; aluoperation = 4'b0000; data1 = 32'd0; data2 = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("mulu_busy_cycles", n, 32'd32);
    chk("mulu_done", {31'b0, done}, 32'd1);
    chk("mulu_result", result, 32'hFFFF_FFFE);
    chk("mulu_hi", hi, 32'd1);
    chk("mulu_flags", {29'b0, zero, lt, gt}, 32'b001);
    @(posedge clk); #1;
    chk("mulu_no_extra_done", {31'b0, done}, 32'd0);
    chk("mulu_hold", result, 32'hFFFF_FFFE);

    go(4'b1000, 32'h0001_0000, 32'h0001_0000, cyc);
    chk("mulu2_lat", cyc, 32'd32);
    chk("mulu2_result", result, 32'h0);
    chk("mulu2_hi", hi, 32'd1);
    chk("mulu2_zero", {31'b0, zero}, 32'd1);

    go(4'b1001, 32'd100, 32'd7, cyc);
    chk("divu_lat", cyc, 32'd32);
    chk("divu_result", result, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_ltgt", {30'b0, lt, gt}, 32'b01);

    go(4'b1001, 32'd9, 32'd0, cyc);
    chk("div0_lat", cyc, 32'd32);
    chk("div0_result", result, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd9);
    chk("div0_zero", {31'b0, zero}, 32'd0);

    go(4'b1001, 32'd3, 32'd10, cyc);
    chk("divu_small_result", result, 32'd0);
    chk("divu_small_hi", hi, 32'd3);
    chk("divu_small_flags", {29'b0, zero, lt, gt}, 32'b110);

    // Reset during DIVU iteration.
    start = 1'b1; aluoperation = 4'b1001; data1 = 32'd1000; data2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_result", result, 32'h0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_flags", {29'b0, zero, lt, gt}, 32'b000);
    chk("midrst_busy_done", {30'b0, busy, done}, 32'b00);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("midrst_no_done", {31'b0, seen_done}, 32'd0);

    go(4'b0000, 32'd4, 32'd4, cyc);
    chk("post_rst_add", result, 32'd8);
    chk("post_rst_done", {31'b0, done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
